// File: rtl/multi_controller_poller_m.sv
// ============================================================================
// Module   : multi_controller_poller_m
// Purpose  : Polls NUM_CONTROLLERS serial gamepads over a shared latch/clock
//            pair and publishes button states plus newly-pressed edge flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_controller_poller_m #(
    parameter int NUM_CONTROLLERS = 2,
    parameter int NUM_BUTTONS     = 8,
    parameter int CLK_DIV         = 6,
    parameter int AUTO_POLL       = 0,
    parameter int POLL_PERIOD     = 16667
) (
    input  logic                                   clk_1,
    input  logic                                   rst,
    input  logic                                   start,
    output logic                                   controller_latch,
    output logic                                   controller_clk,
    input  logic [NUM_CONTROLLERS-1:0]             controller_data_in_B,
    output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] buttons_out,
    output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] buttons_pressed_out,
    output logic                                   busy,
    output logic                                   done
);

    localparam int c_BTN_W = NUM_CONTROLLERS * NUM_BUTTONS;
    localparam int c_PH_W  = $clog2(2 * CLK_DIV);
    localparam int c_BIT_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
    localparam int c_PER_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    localparam logic [c_PH_W-1:0]  c_LATCH_LAST = c_PH_W'(2 * CLK_DIV - 1);
    localparam logic [c_PH_W-1:0]  c_HALF_LAST  = c_PH_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST   = c_BIT_W'(NUM_BUTTONS - 1);
    localparam logic [c_PER_W-1:0] c_PER_LAST   = c_PER_W'(POLL_PERIOD - 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_LATCH    = 3'd1;
    localparam logic [2:0] c_ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] c_ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] c_ST_COMMIT   = 3'd4;

    logic [2:0]               r_state;
    logic [c_PH_W-1:0]        r_phase;
    logic [c_BIT_W-1:0]       r_bit;
    logic [c_PER_W-1:0]       r_period;
    logic [NUM_BUTTONS-1:0]   r_shift [NUM_CONTROLLERS];
    logic [c_BTN_W-1:0]       r_buttons;
    logic [c_BTN_W-1:0]       r_pressed;
    logic [c_BTN_W-1:0]       w_shift_flat;
    logic                     w_auto_trig;
    logic                     w_trigger;

    // Free-running poll period counter; frozen at zero when auto-poll is off.
    always_ff @(posedge clk_1) begin
        if (rst || (AUTO_POLL == 0)) begin
            r_period <= '0;
        end else if (r_period == c_PER_LAST) begin
            r_period <= '0;
        end else begin
            r_period <= r_period + 1'b1;
        end
    end

    assign w_auto_trig = (AUTO_POLL != 0) && (r_period == c_PER_LAST);
    assign w_trigger   = start | w_auto_trig;

    generate
        for (genvar c = 0; c < NUM_CONTROLLERS; c++) begin : g_pack
            assign w_shift_flat[c*NUM_BUTTONS +: NUM_BUTTONS] = r_shift[c];
        end
    endgenerate

    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_phase   <= '0;
            r_bit     <= '0;
            r_buttons <= '0;
            r_pressed <= '0;
            for (int c = 0; c < NUM_CONTROLLERS; c++) begin
                r_shift[c] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_phase <= '0;
                    r_bit   <= '0;
                    if (w_trigger) begin
                        r_state <= c_ST_LATCH;
                    end
                end
                c_ST_LATCH: begin
                    if (r_phase == c_LATCH_LAST) begin
                        r_phase <= '0;
                        r_state <= c_ST_SHIFT_LO;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                c_ST_SHIFT_LO: begin
                    if (r_phase == c_HALF_LAST) begin
                        // Data is sampled at the end of the low phase, just before the rising edge.
                        for (int c = 0; c < NUM_CONTROLLERS; c++) begin
                            r_shift[c][r_bit] <= ~controller_data_in_B[c];
                        end
                        r_phase <= '0;
                        r_state <= c_ST_SHIFT_HI;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                c_ST_SHIFT_HI: begin
                    if (r_phase == c_HALF_LAST) begin
                        r_phase <= '0;
                        if (r_bit == c_BIT_LAST) begin
                            r_state <= c_ST_COMMIT;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_state <= c_ST_SHIFT_LO;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                c_ST_COMMIT: begin
                    r_buttons <= w_shift_flat;
                    r_pressed <= w_shift_flat & ~r_buttons;
                    r_bit     <= '0;
                    r_state   <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign controller_latch    = (r_state == c_ST_LATCH);
    assign controller_clk      = (r_state != c_ST_SHIFT_LO);
    assign busy                = (r_state != c_ST_IDLE);
    assign done                = (r_state == c_ST_COMMIT);
    assign buttons_out         = r_buttons;
    assign buttons_pressed_out = r_pressed;

endmodule

`default_nettype wire

// File: tb/tb_multi_controller_poller_m.sv
// Testbench for multi_controller_poller_m: default-config instance driven by start
// pulses plus an auto-polling 4x12 instance, both checked via scoreboards.
`default_nettype none

module tb_multi_controller_poller_m;

    localparam int NC_A = 2, NB_A = 8, CD_A = 6;
    localparam int NC_B = 4, NB_B = 12, CD_B = 2, PP_B = 100;
    localparam int LAT_A = 2*CD_A + 2*CD_A*NB_A + 1;
    localparam int LAT_B = 2*CD_B + 2*CD_B*NB_B + 1;
    localparam int REL_B = 3;   // first cycle in which the auto-poll counter reads 0

    logic clk_1 = 1'b0;
    always #5 clk_1 = ~clk_1;

    int cyc = 0;
    always @(posedge clk_1) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [47:0] btn;
        logic [47:0] prs;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    // DUT A: default parameters
    logic                    rst_a, start_a, latch_a, cclk_a, busy_a, done_a;
    logic [NC_A-1:0]         data_a;
    logic [NC_A*NB_A-1:0]    buttons_a, pressed_a;
    // DUT B: auto-polling wide configuration
    logic                    rst_b, start_b, latch_b, cclk_b, busy_b, done_b;
    logic [NC_B-1:0]         data_b;
    logic [NC_B*NB_B-1:0]    buttons_b, pressed_b;

    multi_controller_poller_m dut_a (
        .clk_1(clk_1), .rst(rst_a), .start(start_a),
        .controller_latch(latch_a), .controller_clk(cclk_a),
        .controller_data_in_B(data_a),
        .buttons_out(buttons_a), .buttons_pressed_out(pressed_a),
        .busy(busy_a), .done(done_a)
    );

    multi_controller_poller_m #(
        .NUM_CONTROLLERS(NC_B), .NUM_BUTTONS(NB_B), .CLK_DIV(CD_B),
        .AUTO_POLL(1), .POLL_PERIOD(PP_B)
    ) dut_b (
        .clk_1(clk_1), .rst(rst_b), .start(start_b),
        .controller_latch(latch_b), .controller_clk(cclk_b),
        .controller_data_in_B(data_b),
        .buttons_out(buttons_b), .buttons_pressed_out(pressed_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Gamepad models: latch loads the pattern, each controller-clock rise advances it.
    logic [NB_A-1:0] pat_a [NC_A] = '{default: '0};
    logic [NB_B-1:0] pat_b [NC_B] = '{default: '0};
    int idx_a = 0, idx_b = 0;
    always @(posedge latch_a) idx_a = 0;
    always @(posedge cclk_a) if (!latch_a) idx_a++;
    always @(posedge latch_b) idx_b = 0;
    always @(posedge cclk_b) if (!latch_b) idx_b++;

    always_comb begin
        data_a = '1;
        for (int c = 0; c < NC_A; c++)
            if (idx_a < NB_A) data_a[c] = ~pat_a[c][idx_a[2:0]];
    end
    always_comb begin
        data_b = '1;
        for (int c = 0; c < NC_B; c++)
            if (idx_b < NB_B) data_b[c] = ~pat_b[c][idx_b[3:0]];
    end

    // Monitor A: scoreboard pops on done, plus latch/clock waveform timing.
    int   lo_run_a = 0, hi_run_a = 0, lo_cnt_a = 0, lat_run_a = 0, lat_rises_a = 0;
    bit   pend_a = 0, prev_rst_a = 1;
    exp_t cur_a;
    logic [15:0] prev_btn_a = '0;
    always @(negedge clk_1) begin
        if (pend_a) begin
            chk("a_buttons", buttons_a, cur_a.btn[15:0]);
            chk("a_pressed", pressed_a, cur_a.prs[15:0]);
            pend_a = 0;
        end else if (!rst_a && !prev_rst_a && buttons_a !== prev_btn_a) begin
            chk("a_buttons_stable", buttons_a, prev_btn_a);
        end
        prev_btn_a = buttons_a;
        prev_rst_a = rst_a;
        if (rst_a) begin
            lo_run_a = 0; hi_run_a = 0; lo_cnt_a = 0; lat_run_a = 0;
        end else begin
            if (latch_a) lat_run_a++;
            else if (lat_run_a > 0) begin
                chk("a_latch_len", lat_run_a, 2*CD_A);
                lat_rises_a++;
                lat_run_a = 0;
            end
            if (!cclk_a) begin
                if (hi_run_a > 0) begin
                    chk("a_clk_high_len", hi_run_a, CD_A);
                    hi_run_a = 0;
                end
                lo_run_a++;
            end else begin
                if (lo_run_a > 0) begin
                    chk("a_clk_low_len", lo_run_a, CD_A);
                    lo_cnt_a++;
                    lo_run_a = 0;
                end
                if (busy_a && !latch_a && !done_a) hi_run_a++;
            end
        end
        if (done_a) begin
            if (qa.size() == 0) chk("a_unexpected_done", done_a, 0);
            else begin
                cur_a = qa.pop_front();
                chk("a_done_cycle", cyc, cur_a.cyc);
                chk("a_clk_pairs", lo_cnt_a, NB_A);
                chk("a_last_high_len", hi_run_a, CD_A);
                pend_a = 1;
            end
            lo_cnt_a = 0;
            hi_run_a = 0;
        end
        if (qa.size() > 0 && cyc > qa[0].cyc) begin
            chk("a_done_missing", cyc, qa[0].cyc);
            void'(qa.pop_front());
        end
    end

    // Monitor B
    int   lo_run_b = 0, b_done_cnt = 0;
    bit   pend_b = 0, prev_latch_b = 0;
    exp_t cur_b;
    always @(negedge clk_1) begin
        if (pend_b) begin
            chk("b_buttons", buttons_b, cur_b.btn);
            chk("b_pressed", pressed_b, cur_b.prs);
            pend_b = 0;
        end
        if (!rst_b) begin
            if (latch_b && !prev_latch_b) begin
                chk("b_latch_phase", (cyc - REL_B) % PP_B, 0);
                chk("b_busy", busy_b, 1);
            end
            if (!cclk_b) lo_run_b++;
            else if (lo_run_b > 0) begin
                chk("b_clk_low_len", lo_run_b, CD_B);
                lo_run_b = 0;
            end
        end
        prev_latch_b = latch_b;
        if (done_b) begin
            b_done_cnt++;
            if (qb.size() == 0) chk("b_unexpected_done", done_b, 0);
            else begin
                cur_b = qb.pop_front();
                chk("b_done_cycle", cyc, cur_b.cyc);
                pend_b = 1;
            end
        end
        if (qb.size() > 0 && cyc > qb[0].cyc) begin
            chk("b_done_missing", cyc, qb[0].cyc);
            void'(qb.pop_front());
        end
    end

    // Stimulus B: new random patterns each period, expected result queued per wrap.
    int          wrap_b;
    logic [47:0] prev_b = '0, btn_b;
    exp_t        e_b;
    initial begin
        start_b = 1'b0;
        repeat (4) @(posedge clk_1);
        #1;
        for (int i = 0; i < 1000; i++) begin
            wrap_b = REL_B + PP_B - 1 + PP_B*i;
            for (int c = 0; c < NC_B; c++) pat_b[c] = 12'($urandom);
            btn_b   = {pat_b[3], pat_b[2], pat_b[1], pat_b[0]};
            e_b.cyc = wrap_b + LAT_B;
            e_b.btn = btn_b;
            e_b.prs = btn_b & ~prev_b;
            prev_b  = btn_b;
            qb.push_back(e_b);
            while (cyc < wrap_b + 60) begin
                @(posedge clk_1);
                #1;
            end
        end
    end

    // Stimulus A
    logic [15:0] prev_a = '0;
    int          a_polls = 0;

    task automatic poll_a(input logic [7:0] p0, input logic [7:0] p1,
                          input int rst_at, input bit repulse);
        int   s;
        exp_t e;
        pat_a[0] = p0;
        pat_a[1] = p1;
        start_a  = 1'b1;
        s        = cyc;
        a_polls++;
        if (rst_at < 0) begin
            e.cyc = s + LAT_A;
            e.btn = {32'h0, p1, p0};
            e.prs = {32'h0, {p1, p0} & ~prev_a};
            prev_a = {p1, p0};
            qa.push_back(e);
        end
        for (int rel = 1; rel <= LAT_A + 6; rel++) begin
            @(posedge clk_1);
            #1;
            start_a = repulse && (rel == 5 || rel == 50);
            if (rst_at >= 0 && rel == rst_at + 1) begin
                chk("a_rst_abort", {latch_a, cclk_a, busy_a, done_a, buttons_a, pressed_a},
                    {4'b0100, 32'h0});
                prev_a = '0;
            end
            rst_a = (rel == rst_at);
            if (rel == 1) chk("a_busy_latch_start", {busy_a, latch_a}, 2'b11);
            if (rst_at < 0 && rel == LAT_A + 1) chk("a_busy_end", busy_a, 0);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0;
        repeat (3) @(posedge clk_1);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (200) @(posedge clk_1);
        #1;
        chk("a_idle", {latch_a, cclk_a, busy_a, done_a, buttons_a, pressed_a}, {4'b0100, 32'h0});

        poll_a(8'hA5, 8'h3C, -1, 1'b0);
        poll_a(8'hA7, 8'h3C, -1, 1'b0);
        poll_a(8'($urandom), 8'($urandom), -1, 1'b1);
        poll_a(8'($urandom), 8'($urandom), 40, 1'b0);
        repeat (5) begin
            repeat ($urandom_range(0, 7)) @(posedge clk_1);
            #1;
            poll_a(8'($urandom), 8'($urandom), -1, 1'b0);
        end
        repeat (20) @(posedge clk_1);
        #1;
        chk("a_latch_pulses", lat_rises_a, a_polls);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_polls_seen", b_done_cnt >= 8, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
